// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: the L2 controller FSM state encoding.
package lc3b_types;

  typedef enum logic [1:0] {
    L2_CHECK     = 2'd0,
    L2_WRITEBACK = 2'd1,
    L2_FETCH     = 2'd2
  } l2_ctrl_state_t;

endpackage

// File: rtl/l2_cache_control_counter.sv
// Saturating statistics counter with a synchronous clear that overrides increment.
module l2_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: hit/miss lookup, dirty writeback, line fetch and
// saturating hit/miss/writeback statistics.
module l2_cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 cache_hit,
  input  logic                 dirtyout,
  output logic                 write_enable,
  output logic                 cache_allocate,
  output logic                 datain_mux_sel,
  output logic                 valid_in,
  output logic                 dirty_datain,
  output logic                 pmem_address_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  l2_ctrl_state_t state_q, state_d;
  logic miss_pending_q, miss_pending_d;

  logic mem_resp_s, write_enable_s, cache_allocate_s, datain_mux_sel_s;
  logic valid_in_s, dirty_datain_s, pmem_address_sel_s, pmem_read_s, pmem_write_s;
  logic miss_start_s, wb_done_s, hit_inc_s, req_s;

  assign req_s = mem_read | mem_write;

  // Next-state and Mealy datapath/pmem controls; a simultaneous read+write is a write.
  always_comb begin
    state_d            = state_q;
    mem_resp_s         = 1'b0;
    write_enable_s     = 1'b0;
    cache_allocate_s   = 1'b0;
    datain_mux_sel_s   = 1'b0;
    valid_in_s         = 1'b0;
    dirty_datain_s     = 1'b0;
    pmem_address_sel_s = 1'b0;
    pmem_read_s        = 1'b0;
    pmem_write_s       = 1'b0;
    miss_start_s       = 1'b0;
    wb_done_s          = 1'b0;
    case (state_q)
      L2_CHECK: begin
        if (req_s && cache_hit) begin
          mem_resp_s = 1'b1;
          if (mem_write) begin
            write_enable_s   = 1'b1;
            datain_mux_sel_s = 1'b1;
            valid_in_s       = 1'b1;
            dirty_datain_s   = 1'b1;
          end else begin
            write_enable_s   = 1'b0;
          end
        end else if (req_s) begin
          miss_start_s = 1'b1;
          state_d      = dirtyout ? L2_WRITEBACK : L2_FETCH;
        end else begin
          state_d = L2_CHECK;
        end
      end
      L2_WRITEBACK: begin
        pmem_write_s       = 1'b1;
        pmem_address_sel_s = 1'b1;
        if (pmem_resp) begin
          wb_done_s = 1'b1;
          state_d   = L2_FETCH;
        end else begin
          state_d = L2_WRITEBACK;
        end
      end
      L2_FETCH: begin
        pmem_read_s = 1'b1;
        // The line is installed even if the requester has gone away.
        if (pmem_resp) begin
          write_enable_s   = 1'b1;
          cache_allocate_s = 1'b1;
          valid_in_s       = 1'b1;
          state_d          = L2_CHECK;
        end else begin
          state_d = L2_FETCH;
        end
      end
      default: begin
        state_d = L2_CHECK;
      end
    endcase
  end

  // Miss tracking: a completion after a miss is not counted as a hit.
  always_comb begin
    miss_pending_d = miss_pending_q;
    if (miss_start_s) begin
      miss_pending_d = 1'b1;
    end else if (mem_resp_s) begin
      miss_pending_d = 1'b0;
    end else begin
      miss_pending_d = miss_pending_q;
    end
  end

  // State and miss-pending registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= L2_CHECK;
      miss_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      miss_pending_q <= miss_pending_d;
    end
  end

  // Gating by reset_n forces outputs low the moment reset asserts, without a clock.
  assign mem_resp         = reset_n & mem_resp_s;
  assign write_enable     = reset_n & write_enable_s;
  assign cache_allocate   = reset_n & cache_allocate_s;
  assign datain_mux_sel   = reset_n & datain_mux_sel_s;
  assign valid_in         = reset_n & valid_in_s;
  assign dirty_datain     = reset_n & dirty_datain_s;
  assign pmem_address_sel = reset_n & pmem_address_sel_s;
  assign pmem_read        = reset_n & pmem_read_s;
  assign pmem_write       = reset_n & pmem_write_s;

  assign hit_inc_s = mem_resp_s & ~miss_pending_q;

  l2_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .reset_n(reset_n), .inc(hit_inc_s), .clr(clr_stats), .count(hit_count)
  );

  l2_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .reset_n(reset_n), .inc(miss_start_s), .clr(clr_stats), .count(miss_count)
  );

  l2_sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .reset_n(reset_n), .inc(wb_done_s), .clr(clr_stats), .count(wb_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Randomized scoreboard bench for l2_cache_control with a request-level reference model.
module tb_l2_cache_control;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n, mem_read, mem_write, mem_resp, cache_hit, dirtyout;
  logic write_enable, cache_allocate, datain_mux_sel, valid_in, dirty_datain;
  logic pmem_address_sel, pmem_read, pmem_write, pmem_resp, clr_stats;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  l2_cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .cache_hit(cache_hit), .dirtyout(dirtyout),
    .write_enable(write_enable), .cache_allocate(cache_allocate),
    .datain_mux_sel(datain_mux_sel), .valid_in(valid_in), .dirty_datain(dirty_datain),
    .pmem_address_sel(pmem_address_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .clr_stats(clr_stats),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit w;
    int lat;
    int start;
    int hc;
    int mc;
    int wc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_hc = 0, m_mc = 0, m_wc = 0;
  bit   m_pend = 1'b0;
  exp_t cnt_exp;
  bit   cnt_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic int outs();
    return {mem_resp, write_enable, cache_allocate, datain_mux_sel, valid_in,
            dirty_datain, pmem_address_sel, pmem_read, pmem_write};
  endfunction

  // Monitor: pops the scoreboard on every mem_resp, checks counters one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_pend) begin
      chk("hit_count", int'(hit_count), cnt_exp.hc);
      chk("miss_count", int'(miss_count), cnt_exp.mc);
      chk("wb_count", int'(wb_count), cnt_exp.wc);
      cnt_pend = 1'b0;
    end
    if (reset_n === 1'b1 && mem_resp === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_mem_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_latency", cyc - e.start + 1, e.lat);
        chk("resp_write_enable", int'(write_enable), int'(e.w));
        chk("resp_dirty_datain", int'(dirty_datain), int'(e.w));
        chk("resp_mux_sel", int'(datain_mux_sel), int'(e.w));
        chk("resp_valid_in", int'(valid_in), int'(e.w));
        chk("resp_no_alloc", int'(cache_allocate), 0);
        chk("resp_no_pmem", int'(pmem_read | pmem_write), 0);
        cnt_exp  = e;
        cnt_pend = 1'b1;
      end
    end
  end

  // One L1 request; the bench also plays the memory side and the tag array.
  task automatic do_req(input bit w, input bit hit, input bit dirty, input int l1,
                        input int l2, input bit drop, input bit clr);
    exp_t e;
    int   wcnt = 0, rcnt = 0;
    bit   done = 1'b0, drop_now = 1'b0, resp_seen = 1'b0;
    if (hit) begin
      if (!m_pend) m_hc = sat(m_hc);
      m_pend = 1'b0;
      e.lat  = 1;
    end else begin
      m_mc = sat(m_mc);
      if (dirty) m_wc = sat(m_wc);
      m_pend = drop;
      e.lat  = 2 + l2 + (dirty ? l1 : 0);
    end
    if (clr) begin
      m_hc = 0; m_mc = 0; m_wc = 0;
    end
    e.w = w; e.hc = m_hc; e.mc = m_mc; e.wc = m_wc;
    @(posedge clk); #1;
    e.start   = cyc;
    mem_write = w;
    mem_read  = w ? 1'($urandom_range(0, 1)) : 1'b1;
    cache_hit = hit;
    dirtyout  = dirty;
    clr_stats = clr;
    if (!drop) sb.push_back(e);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        if (drop) resp_seen = 1'b1;
        else done = 1'b1;
      end else if (pmem_write === 1'b1) begin
        chk("wb_addr_sel", int'(pmem_address_sel), 1);
        wcnt++;
        pmem_resp = 1'(wcnt == l1);
      end else if (pmem_read === 1'b1) begin
        chk("fetch_addr_sel", int'(pmem_address_sel), 0);
        rcnt++;
        if (drop && rcnt == 1) drop_now = 1'b1;
        pmem_resp = 1'(rcnt == l2);
        if (pmem_resp) begin
          #1;
          chk("fetch_allocate", int'(cache_allocate & write_enable & valid_in), 1);
          chk("fetch_clean_data", int'(dirty_datain | datain_mux_sel), 0);
          cache_hit = 1'b1;
          if (drop) done = 1'b1;
        end
      end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      clr_stats = 1'b0;
      if (drop_now || done) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (!done) chk("request_timeout", 0, 1);
    mem_read = 1'b0; mem_write = 1'b0; cache_hit = 1'b0; dirtyout = 1'b0;
    if (drop) begin
      @(negedge clk);
      chk("drop_no_resp", int'(resp_seen), 0);
      chk("drop_idle_outputs", outs(), 0);
    end
  endtask

  // Idle cycles with stray pmem_resp pulses that the controller must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_outputs", outs(), 0);
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; cache_hit = 1'b0;
    dirtyout = 1'b0; pmem_resp = 1'b0; clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    chk("reset_counters", int'({hit_count, miss_count, wb_count}), 0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Read hit, clean read miss, dirty write miss, write hit.
    do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0);
    do_req(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Saturation and clear-wins.
    repeat (5) do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("hit_saturated", int'(hit_count), MAXC);
    do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

    // Request withdrawn during FETCH, then the next completion is not a hit.
    do_req(1'b0, 1'b0, 1'b0, 0, 3, 1'b1, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit h;
      h = 1'($urandom_range(0, 2) != 0);
      do_req(1'($urandom_range(0, 1)), h, 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        m_hc = 0; m_mc = 0; m_wc = 0;
        @(negedge clk);
        chk("clr_counters", int'({hit_count, miss_count, wb_count}), 0);
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Reset in the middle of a FETCH.
    @(posedge clk); #1;
    mem_read = 1'b1; cache_hit = 1'b0; dirtyout = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_pmem_read", int'(pmem_read), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_drops_pmem_read", int'(pmem_read), 0);
    chk("reset_mid_outputs", outs(), 0);
    chk("reset_mid_counters", int'({hit_count, miss_count, wb_count}), 0);
    mem_read = 1'b0;
    m_hc = 0; m_mc = 0; m_wc = 0; m_pend = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    // A hit right after reset proves the controller is back in CHECK.
    do_req(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
